// File: rtl/ysyx_23060184_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_23060184_ifu -- instruction fetch unit
//
// Fetches one instruction at a time from a read-only memory channel. It hands
// the instruction to decode, then waits for execute to retire it and choose
// the next PC.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   PCSrc                    next-PC select (0=pc+4, 1=PCTarget, 2=ALU, 3=CSR)
//   PCTarget/ALUResult/CsrRead  candidate next-PC values
//   PcUpdate                 retire pulse from execute; applies PCSrc
//   arvalid/araddr/arready   read address channel
//   rvalid/rdata/rresp/rready read data channel
//   inst_valid/inst_ready    decode handshake
//   inst, pc, fetch_fault    fetched word, its address, bus error flag
//   misalign                 last loaded next-PC had bit1 set
//   fetch_cnt                number of completed fetches (wraps)
// ----------------------------------------------------------------------------
module ysyx_23060184_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          PC_SRC_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_SRC_W-1:0] PCSrc,
    input  logic [31:0]         PCTarget,
    input  logic [31:0]         ALUResult,
    input  logic [31:0]         CsrRead,
    input  logic                PcUpdate,
    output logic                arvalid,
    output logic [31:0]         araddr,
    input  logic                arready,
    input  logic                rvalid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    output logic                rready,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst,
    output logic [31:0]         pc,
    output logic                fetch_fault,
    output logic                misalign,
    output logic [31:0]         fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ,
        S_RESP,
        S_OUT,
        S_UPD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_cnt;
    logic        r_fault;
    logic        r_mis;

    logic        w_resp_fire;
    logic        w_upd_acc;
    logic [31:0] w_src_idx;
    logic [31:0] w_sel;
    logic [31:0] w_pc_nxt;

    // A data beat only counts while we are actually waiting for one; rready
    // is low everywhere else, so late or spurious beats fall away here.
    assign w_resp_fire = rvalid & rready;

    // PcUpdate is honoured only once the instruction has left (or is leaving
    // in this very cycle) the decode handshake, so pc never moves while a
    // fetch is outstanding or while decode still looks at it.
    assign w_upd_acc = PcUpdate &
                       (((r_state == S_OUT) && inst_ready) || (r_state == S_UPD));

    assign w_src_idx = 32'(PCSrc);

    always_comb begin
        w_sel = r_pc + 32'd4;
        case (w_src_idx)
            32'd1:   w_sel = PCTarget;
            32'd2:   w_sel = ALUResult & ~32'h1;
            32'd3:   w_sel = CsrRead;
            default: w_sel = r_pc + 32'd4;
        endcase
    end

    // The low two bits are always dropped; bit1 being set is reported via
    // misalign rather than silently hidden.
    assign w_pc_nxt = w_sel & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        arvalid     = 1'b0;
        rready      = 1'b0;
        inst_valid  = 1'b0;
        case (r_state)
            S_REQ: begin
                arvalid = 1'b1;
                if (arready) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rready = 1'b1;
                if (rvalid) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                inst_valid = 1'b1;
                if (inst_ready) w_state_nxt = PcUpdate ? S_REQ : S_UPD;
            end
            S_UPD: begin
                if (PcUpdate) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_inst  <= 32'd0;
            r_fault <= 1'b0;
            r_mis   <= 1'b0;
            r_cnt   <= 32'd0;
        end else begin
            if (w_resp_fire) begin
                r_inst  <= rdata;
                r_fault <= |rresp;
                r_cnt   <= r_cnt + 32'd1;
            end
            if (w_upd_acc) begin
                r_pc  <= w_pc_nxt;
                r_mis <= w_sel[1];
            end
        end
    end

    assign araddr      = r_pc;
    assign pc          = r_pc;
    assign inst        = r_inst;
    assign fetch_fault = r_fault;
    assign misalign    = r_mis;
    assign fetch_cnt   = r_cnt;

endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
module tb_ysyx_23060184_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PCSrc;
    logic [31:0] PCTarget, ALUResult, CsrRead;
    logic        PcUpdate;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fetch_fault;
    logic        misalign;
    logic [31:0] fetch_cnt;

    always #5 clk = ~clk;

    ysyx_23060184_ifu #(.RESET_PC(RST_PC), .PC_SRC_W(2)) dut (
        .clk(clk), .rst(rst), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .ALUResult(ALUResult), .CsrRead(CsrRead), .PcUpdate(PcUpdate),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .pc(pc), .fetch_fault(fetch_fault), .misalign(misalign),
        .fetch_cnt(fetch_cnt)
    );

    int n_err = 0;
    int n_chk = 0;

    // Transaction-level reference state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_inst;
    logic        m_fault;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          rdy_dly;
        bit          same;
        logic [1:0]  src;
        logic [31:0] val;
        logic [31:0] exp_addr;
        logic        exp_mis;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Next PC from the architectural rules, before the low-bit clearing.
    function automatic logic [31:0] model_sel(input logic [1:0] src, input logic [31:0] val,
                                              input logic [31:0] cur);
        case (src)
            2'd0:    return cur + 32'd4;
            2'd2:    return {val[31:1], 1'b0};
            default: return val;
        endcase
    endfunction

    // Selected candidate gets val; the others get noise so a wrong mux leg shows.
    task automatic drive_src(input logic [1:0] src, input logic [31:0] val);
        PCSrc     = src;
        PCTarget  = $urandom;
        ALUResult = $urandom;
        CsrRead   = $urandom;
        case (src)
            2'd1: PCTarget  = val;
            2'd2: ALUResult = val;
            2'd3: CsrRead   = val;
            default: ;
        endcase
    endtask

    task automatic req_phase(input int ar_dly, input bit spur);
        int t = 0;
        while (arvalid !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        chk("arvalid_wait", {31'd0, arvalid}, 32'd1);
        chk("araddr", araddr, m_pc);
        for (int i = 0; i < ar_dly; i++) begin
            arready = 1'b0;
            rvalid  = spur ? 1'(($urandom % 2)) : 1'b0;
            rdata   = $urandom;
            step();
            chk("arvalid_hold", {31'd0, arvalid}, 32'd1);
            chk("araddr_hold", araddr, m_pc);
        end
        rvalid  = 1'b0;
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("resp_rready", {31'd0, rready}, 32'd1);
        chk("resp_arvalid", {31'd0, arvalid}, 32'd0);
        chk("cnt_spur_req", fetch_cnt, m_cnt);
    endtask

    task automatic resp_phase(input logic [31:0] data, input logic [1:0] resp, input int r_dly);
        for (int i = 0; i < r_dly; i++) begin
            rvalid = 1'b0;
            step();
            chk("rready_hold", {31'd0, rready}, 32'd1);
        end
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        step();
        rvalid = 1'b0;
        rdata  = $urandom;
        rresp  = 2'd0;
        m_cnt++;
        m_inst  = data;
        m_fault = (resp != 2'd0);
        chk("inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("inst", inst, m_inst);
        chk("pc", pc, m_pc);
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        chk("fetch_cnt", fetch_cnt, m_cnt);
        chk("rready_low", {31'd0, rready}, 32'd0);
    endtask

    task automatic out_phase(input int rdy_dly, input bit same, input logic [1:0] src,
                             input logic [31:0] val, input bit spur);
        for (int i = 0; i < rdy_dly; i++) begin
            inst_ready = 1'b0;
            rvalid     = spur ? 1'b1 : 1'b0;
            rdata      = $urandom;
            step();
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_inst", inst, m_inst);
            chk("hold_pc", pc, m_pc);
            chk("hold_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
            chk("hold_cnt", fetch_cnt, m_cnt);
        end
        rvalid     = 1'b0;
        inst_ready = 1'b1;
        PcUpdate   = same;
        drive_src(src, val);
        step();
        inst_ready = 1'b0;
        PcUpdate   = 1'b0;
        if (!same) begin
            chk("upd_wait_valid", {31'd0, inst_valid}, 32'd0);
            chk("upd_wait_arvalid", {31'd0, arvalid}, 32'd0);
            chk("upd_wait_pc", pc, m_pc);
        end
    endtask

    task automatic upd_phase(input int dly, input logic [1:0] src, input logic [31:0] val,
                             input bit spur);
        for (int i = 0; i < dly; i++) begin
            drive_src(2'($urandom % 4), $urandom);
            rvalid = spur ? 1'b1 : 1'b0;
            step();
            chk("upd_idle_arvalid", {31'd0, arvalid}, 32'd0);
            chk("upd_idle_pc", pc, m_pc);
            chk("upd_idle_cnt", fetch_cnt, m_cnt);
        end
        rvalid   = 1'b0;
        PcUpdate = 1'b1;
        drive_src(src, val);
        step();
        PcUpdate = 1'b0;
    endtask

    task automatic after_update(input logic [31:0] exp_addr, input logic exp_mis);
        m_pc = exp_addr;
        chk("next_arvalid", {31'd0, arvalid}, 32'd1);
        chk("next_araddr", araddr, exp_addr);
        chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_cnt   = 32'd0;
        m_inst  = 32'd0;
        m_fault = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_rready"}, {31'd0, rready}, 32'd0);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
        chk({tag, "_mis"}, {31'd0, misalign}, 32'd0);
        chk({tag, "_cnt"}, fetch_cnt, 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'h0000_0013, 2'd0, 0, 1'b1, 2'd0, 32'h0,         32'h8000_0004, 1'b0};
        tbl[1] = '{32'h0010_0093, 2'd2, 5, 1'b0, 2'd2, 32'h8000_0101, 32'h8000_0100, 1'b0};
        tbl[2] = '{32'h0000_0073, 2'd0, 0, 1'b0, 2'd2, 32'h8000_0102, 32'h8000_0100, 1'b1};
        tbl[3] = '{32'h0000_006F, 2'd1, 2, 1'b1, 2'd1, 32'h8000_1000, 32'h8000_1000, 1'b0};
        tbl[4] = '{32'h1234_5678, 2'd0, 0, 1'b0, 2'd1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        tbl[5] = '{32'hDEAD_BEEF, 2'd3, 1, 1'b1, 2'd0, 32'h0,         32'h0000_0000, 1'b0};
        tbl[6] = '{32'h0000_8067, 2'd0, 0, 1'b0, 2'd3, 32'h8000_0200, 32'h8000_0200, 1'b0};
        tbl[7] = '{32'h1111_1111, 2'd0, 0, 1'b0, 2'd3, 32'h8000_0206, 32'h8000_0204, 1'b1};
        tbl[8] = '{32'h2222_2222, 2'd0, 3, 1'b1, 2'd0, 32'h0,         32'h8000_0208, 1'b0};
        tbl[9] = '{32'h3333_3333, 2'd0, 0, 1'b0, 2'd1, 32'h8000_0003, 32'h8000_0000, 1'b1};

        rst = 1'b1;
        PCSrc = 2'd0; PCTarget = 32'd0; ALUResult = 32'd0; CsrRead = 32'd0;
        PcUpdate = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
        rresp = 2'd0; inst_ready = 1'b0;
        model_reset();
        step();
        step();
        check_reset_state("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_arvalid", {31'd0, arvalid}, 32'd1);
        chk("rel_araddr", araddr, RST_PC);

        // Directed vector table
        for (int v = 0; v < 10; v++) begin
            req_phase(v % 2, 1'b1);
            resp_phase(tbl[v].data, tbl[v].resp, v % 3);
            out_phase(tbl[v].rdy_dly, tbl[v].same, tbl[v].src, tbl[v].val, 1'b1);
            if (!tbl[v].same) upd_phase(1 + v % 2, tbl[v].src, tbl[v].val, 1'b1);
            after_update(tbl[v].exp_addr, tbl[v].exp_mis);
        end

        // Reset while a response is outstanding, then a stale beat
        req_phase(0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_state("rst_resp");
        @(negedge clk);
        rst    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hBAD0_BAD0;
        rresp  = 2'd2;
        step();
        rvalid = 1'b0;
        rresp  = 2'd0;
        chk("late_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("late_arvalid", {31'd0, arvalid}, 32'd1);
        chk("late_araddr", araddr, RST_PC);
        chk("late_cnt", fetch_cnt, 32'd0);
        chk("late_inst", inst, 32'd0);

        // Reset while decode holds an instruction
        req_phase(0, 1'b0);
        resp_phase(32'h0000_0513, 2'd1, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_state("rst_out");
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Randomized transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  src;
            logic [31:0] val;
            logic [31:0] sel;
            bit          same;
            src  = 2'($urandom % 4);
            case ($urandom % 4)
                0:       val = 32'hFFFF_FFFC;
                1:       val = $urandom | 32'h3;
                default: val = $urandom;
            endcase
            same = 1'($urandom % 2);
            req_phase($urandom % 3, 1'b1);
            resp_phase($urandom, 2'($urandom % 4), $urandom % 3);
            sel = model_sel(src, val, m_pc);
            out_phase($urandom % 3, same, src, val, 1'b1);
            if (!same) upd_phase($urandom % 3, src, val, 1'b1);
            after_update(sel & 32'hFFFF_FFFC, sel[1]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ysyx_23060184_ifu.md
YSYX_23060184_IFU -- requirements
Module: ysyx_23060184_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter PC_SRC_W, default 2, width of the next-PC select code.
REQ-003 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: PCSrc  in  PC_SRC_W  next-PC select (0=PCPlus4, 1=PCTarget, 2=ALU, 3=CSRREAD).
REQ-005 SHALL have ports: PCTarget, ALUResult, CsrRead  in  32 each  candidate next-PC values.
REQ-006 SHALL have port: PcUpdate  in  1  one-cycle pulse from execute; current instruction retired, apply PCSrc.
REQ-007 SHALL have memory read ports: arvalid out 1; araddr out 32; arready in 1; rvalid in 1; rdata in 32; rresp in 2; rready out 1.
REQ-008 SHALL have decode-side ports: inst_valid out 1; inst_ready in 1; inst out 32; pc out 32; fetch_fault out 1; misalign out 1.
REQ-009 SHALL have port: fetch_cnt  out  32  count of completed fetches.

Function
REQ-010 SHALL implement FSM states S_REQ, S_RESP, S_OUT, S_UPD.
REQ-011 SHALL hold arvalid=1 and araddr=pc in S_REQ; on arvalid&arready go to S_RESP next cycle.
REQ-012 SHALL hold rready=1 only in S_RESP; on rvalid, latch rdata into inst and rresp!=0 into fetch_fault, then go to S_OUT.
REQ-013 SHALL hold inst_valid=1 only in S_OUT; inst, pc and fetch_fault SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-014 SHALL leave S_OUT when inst_valid&inst_ready: to S_UPD, or directly to S_REQ if PcUpdate is high in the same cycle.
REQ-015 SHALL, in S_UPD, wait indefinitely for PcUpdate, then go to S_REQ.
REQ-016 SHALL load pc on each accepted PcUpdate: 0 -> pc+4; 1 -> PCTarget; 2 -> ALUResult with bit0 cleared; 3 -> CsrRead.
REQ-017 SHALL compute pc+4 modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-018 SHALL force bits[1:0] of a loaded next PC to 0; misalign SHALL be set when the selected value had bit1=1, and cleared on the next accepted PcUpdate with an aligned value.
REQ-019 SHALL ignore PcUpdate in S_REQ and S_RESP; pc SHALL not change while a fetch is outstanding.
REQ-020 SHALL treat rvalid in states other than S_RESP as spurious and ignore it.
REQ-021 SHALL increment fetch_cnt by 1 on each rvalid&rready; it wraps from 32'hFFFF_FFFF to 0.
REQ-022 SHALL have minimum latency from PcUpdate to next arvalid of 1 cycle, and from rvalid to inst_valid of 1 cycle.

Reset
REQ-023 SHALL, while rst=1, force state S_REQ, pc=RESET_PC, inst=0, fetch_fault=0, misalign=0, fetch_cnt=0, inst_valid=0, rready=0.
REQ-024 SHALL drive arvalid=1, araddr=RESET_PC in the first cycle after rst deasserts.
REQ-025 SHALL, on reset mid-transaction (S_RESP/S_OUT), abandon the transaction; a late rvalid after reset is ignored per REQ-020.

Verification
REQ-026 Reset release, arready=1, rvalid next cycle with rdata=32'h0000_0013, rresp=0 -> inst_valid=1, inst=32'h13, pc=32'h8000_0000, fetch_cnt=1.
REQ-027 inst_ready=1, PcUpdate=1 same cycle, PCSrc=0 -> araddr=32'h8000_0004 next cycle, state S_REQ.
REQ-028 PCSrc=2, ALUResult=32'h8000_0101, PcUpdate -> araddr=32'h8000_0100, misalign=0; ALUResult=32'h8000_0102 -> araddr=32'h8000_0100, misalign=1.
REQ-029 rresp=2'b10 on rvalid -> inst_valid=1 with fetch_fault=1; inst_ready held low 5 cycles -> inst, pc, fetch_fault unchanged.
REQ-030 rst pulsed in S_RESP, then rvalid without a new request -> ignored, inst_valid=0, arvalid=1 with araddr=RESET_PC.
REQ-031 pc=32'hFFFF_FFFC, PCSrc=0, PcUpdate -> araddr=0; PCSrc=3, CsrRead=32'h8000_0200 -> araddr=32'h8000_0200.
